// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the reset sequencer.
package reset_seq_pkg;

   localparam int unsigned DLY_W = 16;
   localparam int unsigned TO_W  = 16;

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StDelay    = 2'd1,
      StWaitAck  = 2'd2,
      StDone     = 2'd3
   } state_e;

endpackage

// File: rtl/reset_seq_lock_filt.sv
// PLL lock filter: lock_ok once pll_locked has been high LOCK_FILT consecutive cycles;
// lock_lost flags a drop of lock while the sequencer is past the lock-wait phase.
module reset_seq_lock_filt #(
   parameter int unsigned LOCK_FILT = 16
) (
   input  logic clk,
   input  logic reset_in,
   input  logic en,
   input  logic clr,
   input  logic pll_locked,
   output logic lock_ok,
   output logic lock_lost
);

   localparam int unsigned CNT_W = $clog2(LOCK_FILT + 1);

   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (clr || !en || !pll_locked) begin
         lock_cnt_d = '0;
      end else if (lock_cnt_q < CNT_W'(LOCK_FILT)) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         lock_cnt_q <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Qualifies on the edge where the count reaches LOCK_FILT, not one cycle later.
   assign lock_ok   = en && pll_locked && (lock_cnt_q >= CNT_W'(LOCK_FILT - 1));
   assign lock_lost = !en && !pll_locked;

endmodule

// File: rtl/reset_seq.sv
// Power-on/soft reset sequencer: after a filtered PLL lock, releases NUM_STAGES reset
// domains in ascending order, each after a delay and an optional ack handshake.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned LOCK_FILT  = 16,
   parameter int unsigned STAGE_DLY  = 255,
   parameter int unsigned ACK_EN     = 0,
   parameter int unsigned ACK_TO     = 4095
) (
   input  logic                  clk,
   input  logic                  reset_in,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  seq_done,
   output logic [2:0]            cur_stage,
   output logic                  ack_timeout_err,
   output logic [2:0]            err_stage
);

   state_e                  state_q, state_d;
   logic [2:0]              stage_q, stage_d;
   logic [DLY_W-1:0]        dly_cnt_q, dly_cnt_d;
   logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
   logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
   logic                    seq_done_q, seq_done_d;
   logic                    err_q, err_d;
   logic [2:0]              err_stage_q, err_stage_d;

   logic lock_ok, lock_lost, restart, adv, ack_cur;

   reset_seq_lock_filt #(
      .LOCK_FILT (LOCK_FILT)
   ) u_lock_filt (
      .clk        (clk),
      .reset_in   (reset_in),
      .en         (state_q == StWaitLock),
      .clr        (sw_reset_req),
      .pll_locked (pll_locked),
      .lock_ok    (lock_ok),
      .lock_lost  (lock_lost)
   );

   assign restart = sw_reset_req || lock_lost;

   always_comb begin
      ack_cur = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_q == 3'(i)) ack_cur = stage_ack[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      dly_cnt_d   = dly_cnt_q;
      to_cnt_d    = to_cnt_q;
      rst_out_d   = rst_out_q;
      seq_done_d  = seq_done_q;
      err_d       = err_q;
      err_stage_d = err_stage_q;
      adv         = 1'b0;

      // Restart wins over any release or advance due this cycle; error flag survives it.
      if (restart) begin
         state_d    = StWaitLock;
         stage_d    = '0;
         dly_cnt_d  = '0;
         to_cnt_d   = '0;
         rst_out_d  = '1;
         seq_done_d = 1'b0;
      end else begin
         unique case (state_q)
            StWaitLock: begin
               if (lock_ok) begin
                  state_d   = StDelay;
                  stage_d   = '0;
                  dly_cnt_d = DLY_W'(STAGE_DLY);
               end
            end
            StDelay: begin
               if (dly_cnt_q == '0) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (stage_q == 3'(i)) rst_out_d[i] = 1'b0;
                  end
                  if (ACK_EN != 0) begin
                     state_d  = StWaitAck;
                     to_cnt_d = '0;
                  end else begin
                     adv = 1'b1;
                  end
               end else begin
                  dly_cnt_d = dly_cnt_q - DLY_W'(1);
               end
            end
            StWaitAck: begin
               if (ack_cur) begin
                  adv = 1'b1;
               end else if (to_cnt_q == TO_W'(ACK_TO - 1)) begin
                  err_d = 1'b1;
                  if (!err_q) err_stage_d = stage_q;
                  adv = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
            StDone: begin
            end
            default: state_d = StWaitLock;
         endcase

         if (adv) begin
            if (stage_q == 3'(NUM_STAGES - 1)) begin
               state_d    = StDone;
               seq_done_d = 1'b1;
               rst_out_d  = '0;
            end else begin
               state_d   = StDelay;
               stage_d   = stage_q + 3'd1;
               dly_cnt_d = DLY_W'(STAGE_DLY);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= StWaitLock;
         stage_q     <= '0;
         dly_cnt_q   <= '0;
         to_cnt_q    <= '0;
         rst_out_q   <= '1;
         seq_done_q  <= 1'b0;
         err_q       <= 1'b0;
         err_stage_q <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         dly_cnt_q   <= dly_cnt_d;
         to_cnt_q    <= to_cnt_d;
         rst_out_q   <= rst_out_d;
         seq_done_q  <= seq_done_d;
         err_q       <= err_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign rst_out         = rst_out_q;
   assign seq_done        = seq_done_q;
   assign cur_stage       = stage_q;
   assign ack_timeout_err = err_q;
   assign err_stage       = err_stage_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench: one sequencer without ack handshake (a) and one with it (b).
module tb_reset_seq;

   logic       clk;
   logic       rst_a, lock_a, sw_a;
   logic [3:0] ack_a;
   logic [3:0] rst_out_a;
   logic       done_a, err_a;
   logic [2:0] cur_a, errst_a;

   logic       rst_b, lock_b, sw_b;
   logic [3:0] ack_b;
   logic [3:0] rst_out_b;
   logic       done_b, err_b;
   logic [2:0] cur_b, errst_b;

   int n_chk;
   int n_fail;

   reset_seq #(
      .NUM_STAGES (4),
      .LOCK_FILT  (4),
      .STAGE_DLY  (3),
      .ACK_EN     (0),
      .ACK_TO     (10)
   ) u_dut_a (
      .clk             (clk),
      .reset_in        (rst_a),
      .pll_locked      (lock_a),
      .sw_reset_req    (sw_a),
      .stage_ack       (ack_a),
      .rst_out         (rst_out_a),
      .seq_done        (done_a),
      .cur_stage       (cur_a),
      .ack_timeout_err (err_a),
      .err_stage       (errst_a)
   );

   reset_seq #(
      .NUM_STAGES (4),
      .LOCK_FILT  (4),
      .STAGE_DLY  (3),
      .ACK_EN     (1),
      .ACK_TO     (10)
   ) u_dut_b (
      .clk             (clk),
      .reset_in        (rst_b),
      .pll_locked      (lock_b),
      .sw_reset_req    (sw_b),
      .stage_ack       (ack_b),
      .rst_out         (rst_out_b),
      .seq_done        (done_b),
      .cur_stage       (cur_b),
      .ack_timeout_err (err_b),
      .err_stage       (errst_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_a = 1'b1; lock_a = 1'b0; sw_a = 1'b0; ack_a = 4'b0000;
      rst_b = 1'b1; lock_b = 1'b0; sw_b = 1'b0; ack_b = 4'b0000;
      tick(2);
      chk("a_reset_rst_out", 32'(rst_out_a), 32'hF);
      chk("a_reset_done", 32'(done_a), 32'd0);
      chk("a_reset_cur", 32'(cur_a), 32'd0);
      chk("b_reset_err", 32'(err_b), 32'd0);
      chk("b_reset_errst", 32'(errst_b), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick(1);

      // Basic release: edges 8, 12, 16, 20 after first locked sample.
      lock_a = 1'b1;
      tick(7);
      chk("basic_e7", 32'(rst_out_a), 32'hF);
      tick(1);
      chk("basic_e8", 32'(rst_out_a), 32'hE);
      chk("basic_e8_cur", 32'(cur_a), 32'd1);
      tick(4);
      chk("basic_e12", 32'(rst_out_a), 32'hC);
      tick(4);
      chk("basic_e16", 32'(rst_out_a), 32'h8);
      chk("basic_e16_cur", 32'(cur_a), 32'd3);
      tick(3);
      chk("basic_e19_done", 32'(done_a), 32'd0);
      tick(1);
      chk("basic_e20", 32'(rst_out_a), 32'h0);
      chk("basic_e20_done", 32'(done_a), 32'd1);
      chk("basic_e20_cur", 32'(cur_a), 32'd3);

      // Lock loss in DONE, then full repeat.
      lock_a = 1'b0;
      tick(1);
      chk("loss_rst_out", 32'(rst_out_a), 32'hF);
      chk("loss_done", 32'(done_a), 32'd0);
      chk("loss_cur", 32'(cur_a), 32'd0);
      lock_a = 1'b1;
      tick(7);
      chk("relock_e7", 32'(rst_out_a), 32'hF);
      tick(1);
      chk("relock_e8", 32'(rst_out_a), 32'hE);
      tick(12);
      chk("relock_e20", 32'(rst_out_a), 32'h0);
      chk("relock_e20_done", 32'(done_a), 32'd1);

      // Lock glitch: 3 high, 1 low, then high.
      lock_a = 1'b0;
      tick(1);
      lock_a = 1'b1;
      tick(3);
      chk("glitch_pre", 32'(rst_out_a), 32'hF);
      lock_a = 1'b0;
      tick(1);
      lock_a = 1'b1;
      tick(7);
      chk("glitch_e7", 32'(rst_out_a), 32'hF);
      tick(1);
      chk("glitch_e8", 32'(rst_out_a), 32'hE);

      // Abort on the edge that would release stage 1.
      tick(3);
      chk("abort_pre", 32'(rst_out_a), 32'hE);
      sw_a = 1'b1;
      tick(1);
      sw_a = 1'b0;
      chk("abort_rst_out", 32'(rst_out_a), 32'hF);
      chk("abort_cur", 32'(cur_a), 32'd0);
      chk("abort_done", 32'(done_a), 32'd0);
      tick(7);
      chk("abort_e7", 32'(rst_out_a), 32'hF);
      tick(1);
      chk("abort_e8", 32'(rst_out_a), 32'hE);

      // Ack handshake and timeout on sequencer b.
      lock_b = 1'b1;
      tick(8);
      chk("ack_e8", 32'(rst_out_b), 32'hE);
      chk("ack_e8_cur", 32'(cur_b), 32'd0);
      ack_b = 4'b0010;
      tick(4);
      chk("ack_wait0_rst", 32'(rst_out_b), 32'hE);
      chk("ack_wait0_cur", 32'(cur_b), 32'd0);
      ack_b = 4'b0011;
      tick(1);
      chk("ack0_cur", 32'(cur_b), 32'd1);
      ack_b = 4'b0010;
      tick(3);
      chk("ack_e16", 32'(rst_out_b), 32'hE);
      tick(1);
      chk("ack_e17", 32'(rst_out_b), 32'hC);
      chk("ack_e17_cur", 32'(cur_b), 32'd1);
      tick(1);
      chk("ack1_cur", 32'(cur_b), 32'd2);
      ack_b = 4'b1010;
      tick(4);
      chk("ack_e22", 32'(rst_out_b), 32'h8);
      tick(9);
      chk("to_e31_err", 32'(err_b), 32'd0);
      chk("to_e31_cur", 32'(cur_b), 32'd2);
      tick(1);
      chk("to_e32_err", 32'(err_b), 32'd1);
      chk("to_e32_errst", 32'(errst_b), 32'd2);
      chk("to_e32_cur", 32'(cur_b), 32'd3);
      chk("to_e32_rst", 32'(rst_out_b), 32'h8);
      tick(4);
      chk("to_e36_rst", 32'(rst_out_b), 32'h0);
      chk("to_e36_done", 32'(done_b), 32'd0);
      tick(1);
      chk("to_e37_done", 32'(done_b), 32'd1);
      sw_b = 1'b1;
      tick(1);
      sw_b = 1'b0;
      chk("sw_rst_out", 32'(rst_out_b), 32'hF);
      chk("sw_done", 32'(done_b), 32'd0);
      chk("sw_err_kept", 32'(err_b), 32'd1);
      chk("sw_errst_kept", 32'(errst_b), 32'd2);

      // Asynchronous reset clears the sticky flag without a clock edge.
      #1;
      rst_b = 1'b1;
      #2;
      chk("async_err", 32'(err_b), 32'd0);
      chk("async_errst", 32'(errst_b), 32'd0);
      tick(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
